// File: rtl/axis_width_conv_gen.sv
// Stream width converter, N-bit beats in, M-bit words out, MSB-first packing.
// Handles any N:M ratio, pads partial words on packet boundary or flush.
module axis_width_conv_gen #(
    parameter int   N   = 4,
    parameter int   M   = 8,
    parameter logic PAD = 1'b0,
    parameter int   CW  = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  s_axis_tdata,
    input  logic          s_axis_tfirst,
    input  logic          s_axis_tvalid,
    output logic          s_axis_tnext,
    output logic [M-1:0]  m_axis_tdata,
    output logic          m_axis_tfirst,
    output logic          m_axis_tvalid,
    input  logic          m_axis_tnext,
    input  logic          flush,
    output logic [CW-1:0] bit_count
);

    localparam int BUF_W = N + M;

    logic [BUF_W-1:0] data_q;
    logic [CW-1:0]    count_q;
    logic             first_q;
    logic             flush_pending;

    logic             full;
    logic             has_bits;
    logic             closing;
    logic             pad_word;
    logic             take;
    logic             accept;
    logic [M-1:0]     top;
    logic [M-1:0]     pad_mask;
    logic [CW-1:0]    take_bits;
    logic [CW-1:0]    count_after;
    logic [CW-1:0]    count_next;
    logic [BUF_W-1:0] data_after;
    logic [BUF_W-1:0] data_next;
    logic [BUF_W-1:0] in_ext;

    assign full     = count_q >= CW'(M);
    assign has_bits = count_q != '0;
    assign closing  = flush_pending | (s_axis_tvalid & s_axis_tfirst);
    assign pad_word = closing & has_bits & !full;

    assign m_axis_tvalid = full | pad_word;
    assign m_axis_tfirst = first_q & m_axis_tvalid;

    // Bits below count_q are always zero, so only the pad mask needs merging.
    assign top      = data_q[BUF_W-1 -: M];
    assign pad_mask = {M{1'b1}} >> count_q;
    assign m_axis_tdata = pad_word ? ((top & ~pad_mask) | ({M{PAD}} & pad_mask)) : top;

    // A tfirst beat waits for an empty buffer; rst gating keeps tnext low in reset.
    assign s_axis_tnext = rst & s_axis_tvalid & (count_q <= CW'(M)) & !flush_pending
                        & (!s_axis_tfirst | !has_bits);
    assign accept = s_axis_tnext;
    assign take   = m_axis_tvalid & m_axis_tnext;

    assign take_bits   = !take ? '0 : (full ? CW'(M) : count_q);
    assign count_after = count_q - take_bits;
    assign count_next  = count_after + (accept ? CW'(N) : '0);

    // A padded take never coincides with an accept, so clearing is safe.
    assign data_after = take ? (pad_word ? '0 : (data_q << M)) : data_q;
    assign in_ext     = BUF_W'(s_axis_tdata) << M;
    assign data_next  = data_after | (accept ? (in_ext >> count_after) : '0);

    assign bit_count = count_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q        <= '0;
            count_q       <= '0;
            first_q       <= 1'b0;
            flush_pending <= 1'b0;
        end else begin
            data_q        <= data_next;
            count_q       <= count_next;
            flush_pending <= (flush_pending | flush) & (count_next != '0);
            if (accept & s_axis_tfirst)
                first_q <= 1'b1;
            else if (take)
                first_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_width_conv_gen.sv
// Directed bench for axis_width_conv_gen: N4/M8, N3/M8 with both pad values, N8/M4.
module tb_axis_width_conv_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // u0: N=4, M=8
    logic [3:0]  s0_data = '0;
    logic        s0_first = 1'b0, s0_valid = 1'b0, s0_tnext;
    logic [7:0]  m0_data;
    logic        m0_first, m0_valid, m0_tnext;
    logic        m0_auto = 1'b1, f0 = 1'b0;
    logic [15:0] cnt0;
    assign m0_tnext = m0_auto & m0_valid;

    // u1/u2: N=3, M=8, PAD 0 and 1, shared stimulus
    logic [2:0]  s1_data = '0;
    logic        s1_first = 1'b0, s1_valid = 1'b0, s1_tnext, s2_tnext;
    logic [7:0]  m1_data, m2_data;
    logic        m1_first, m1_valid, m2_first, m2_valid;
    logic        f12 = 1'b0;
    logic [15:0] cnt1, cnt2;

    // u3: N=8, M=4
    logic [7:0]  s3_data = '0;
    logic        s3_first = 1'b0, s3_valid = 1'b0, s3_tnext;
    logic [3:0]  m3_data;
    logic        m3_first, m3_valid;
    logic        f3 = 1'b0;
    logic [15:0] cnt3;

    axis_width_conv_gen #(.N(4), .M(8), .PAD(1'b0), .CW(16)) u0 (
        .clk(clk), .rst(rst), .s_axis_tdata(s0_data), .s_axis_tfirst(s0_first),
        .s_axis_tvalid(s0_valid), .s_axis_tnext(s0_tnext), .m_axis_tdata(m0_data),
        .m_axis_tfirst(m0_first), .m_axis_tvalid(m0_valid), .m_axis_tnext(m0_tnext),
        .flush(f0), .bit_count(cnt0));

    axis_width_conv_gen #(.N(3), .M(8), .PAD(1'b0), .CW(16)) u1 (
        .clk(clk), .rst(rst), .s_axis_tdata(s1_data), .s_axis_tfirst(s1_first),
        .s_axis_tvalid(s1_valid), .s_axis_tnext(s1_tnext), .m_axis_tdata(m1_data),
        .m_axis_tfirst(m1_first), .m_axis_tvalid(m1_valid), .m_axis_tnext(m1_valid),
        .flush(f12), .bit_count(cnt1));

    axis_width_conv_gen #(.N(3), .M(8), .PAD(1'b1), .CW(16)) u2 (
        .clk(clk), .rst(rst), .s_axis_tdata(s1_data), .s_axis_tfirst(s1_first),
        .s_axis_tvalid(s1_valid), .s_axis_tnext(s2_tnext), .m_axis_tdata(m2_data),
        .m_axis_tfirst(m2_first), .m_axis_tvalid(m2_valid), .m_axis_tnext(m2_valid),
        .flush(f12), .bit_count(cnt2));

    axis_width_conv_gen #(.N(8), .M(4), .PAD(1'b0), .CW(16)) u3 (
        .clk(clk), .rst(rst), .s_axis_tdata(s3_data), .s_axis_tfirst(s3_first),
        .s_axis_tvalid(s3_valid), .s_axis_tnext(s3_tnext), .m_axis_tdata(m3_data),
        .m_axis_tfirst(m3_first), .m_axis_tvalid(m3_valid), .m_axis_tnext(m3_valid),
        .flush(f3), .bit_count(cnt3));

    // Words popped from u0, {tfirst, data}
    logic [8:0] q0[$];
    always @(negedge clk) if (m0_valid && m0_tnext) q0.push_back({m0_first, m0_data});

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a beat to u0 until accepted; returns the number of stalled cycles.
    task automatic send0(input logic [3:0] d, input logic f, output int waited);
        int k;
        s0_data = d; s0_first = f; s0_valid = 1'b1; k = 0;
        @(negedge clk);
        while (!s0_tnext && k < 50) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (s0_tnext !== 1'b1) begin
            errors++;
            $display("FAIL send0_timeout: beat %h not accepted after %0d cycles", d, k);
        end
        waited = k;
        step();
        s0_valid = 1'b0;
    endtask

    task automatic check_q0(input string name, input logic [8:0] exp[$]);
        checks++;
        if (q0.size() !== exp.size()) begin
            errors++;
            $display("FAIL %s_count: got %0d words expected %0d", name, q0.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                checks++;
                if (q0[i] !== exp[i]) begin
                    errors++;
                    $display("FAIL %s_word%0d: got %h expected %h", name, i, q0[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset();
        s0_valid = 1'b1; s0_data = 4'hF; s1_valid = 1'b1; s3_valid = 1'b1;
        #12;
        checks++;
        if ({s0_tnext, m0_valid, m0_first, m0_data, cnt0} !== '0) begin
            errors++;
            $display("FAIL reset_u0: got tn=%b v=%b t=%b d=%h c=%0d expected all 0",
                     s0_tnext, m0_valid, m0_first, m0_data, cnt0);
        end
        checks++;
        if ({s2_tnext, m2_valid, m2_data, cnt2, s3_tnext, m3_valid, cnt3} !== '0) begin
            errors++;
            $display("FAIL reset_u2u3: got tn2=%b v2=%b d2=%h tn3=%b expected all 0",
                     s2_tnext, m2_valid, m2_data, s3_tnext);
        end
        s0_valid = 1'b0; s1_valid = 1'b0; s3_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        checks++;
        if ({s0_tnext, m0_valid, m0_data, cnt0, m3_valid, cnt3} !== '0) begin
            errors++;
            $display("FAIL reset_release: got v=%b d=%h c=%0d expected 0", m0_valid, m0_data, cnt0);
        end
    endtask

    task automatic test_narrow_to_wide();
        logic [3:0]  nib[4]  = '{4'hA, 4'hB, 4'hC, 4'hD};
        logic [15:0] ecnt[4] = '{16'd4, 16'd8, 16'd4, 16'd8};
        int w;
        q0.delete();
        for (int i = 0; i < 4; i++) begin
            send0(nib[i], i == 0, w);
            checks++;
            if (w !== 0) begin
                errors++;
                $display("FAIL n2w_stall%0d: got %0d stall cycles expected 0", i, w);
            end
            checks++;
            if (cnt0 !== ecnt[i]) begin
                errors++;
                $display("FAIL n2w_count%0d: got %0d expected %0d", i, cnt0, ecnt[i]);
            end
        end
        step();
        checks++;
        if (cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL n2w_drain: got %0d expected 0", cnt0);
        end
        check_q0("n2w", '{9'h1AB, 9'h0CD});
    endtask

    task automatic test_odd_ratio_flush();
        logic [2:0] beats[3] = '{3'b101, 3'b110, 3'b011};
        for (int i = 0; i < 3; i++) begin
            s1_valid = 1'b1; s1_data = beats[i];
            @(negedge clk);
            checks++;
            if (s1_tnext !== 1'b1) begin
                errors++;
                $display("FAIL odd_accept%0d: got %b expected 1", i, s1_tnext);
            end
            step();
        end
        s1_valid = 1'b0;
        checks++;
        if ({m1_valid, m1_data, m2_data, cnt1} !== {1'b1, 8'hB9, 8'hB9, 16'd9}) begin
            errors++;
            $display("FAIL odd_word: got v=%b d1=%h d2=%h c=%0d expected v=1 b9 b9 9",
                     m1_valid, m1_data, m2_data, cnt1);
        end
        step();
        checks++;
        if ({m1_valid, cnt1, cnt2} !== {1'b0, 16'd1, 16'd1}) begin
            errors++;
            $display("FAIL odd_residue: got v=%b c1=%0d c2=%0d expected 0 1 1", m1_valid, cnt1, cnt2);
        end
        f12 = 1'b1;
        step();
        f12 = 1'b0;
        checks++;
        if ({m1_valid, m1_data, m1_first} !== {1'b1, 8'h80, 1'b0}) begin
            errors++;
            $display("FAIL flush_pad0: got v=%b d=%h t=%b expected 1 80 0", m1_valid, m1_data, m1_first);
        end
        checks++;
        if ({m2_valid, m2_data} !== {1'b1, 8'hFF}) begin
            errors++;
            $display("FAIL flush_pad1: got v=%b d=%h expected 1 ff", m2_valid, m2_data);
        end
        step();
        checks++;
        if ({m1_valid, cnt1, m2_valid, cnt2} !== '0) begin
            errors++;
            $display("FAIL flush_done: got v1=%b c1=%0d v2=%b c2=%0d expected 0", m1_valid, cnt1, m2_valid, cnt2);
        end
    endtask

    task automatic test_packet_boundary();
        int w;
        q0.delete();
        send0(4'hA, 1'b1, w);
        send0(4'hB, 1'b0, w);
        send0(4'hC, 1'b0, w);
        send0(4'hD, 1'b1, w);
        checks++;
        if (w < 1) begin
            errors++;
            $display("FAIL boundary_stall: got %0d stall cycles expected >=1", w);
        end
        send0(4'hE, 1'b0, w);
        repeat (3) step();
        check_q0("boundary", '{9'h1AB, 9'h0C0, 9'h1DE});
    endtask

    task automatic test_back_to_back();
        int w;
        q0.delete();
        m0_auto = 1'b0;
        send0(4'h1, 1'b1, w);
        send0(4'h2, 1'b0, w);
        send0(4'h3, 1'b0, w);
        s0_valid = 1'b1; s0_data = 4'h4; s0_first = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s0_tnext, cnt0, m0_valid, m0_data} !== {1'b0, 16'd12, 1'b1, 8'h12}) begin
            errors++;
            $display("FAIL stall_state: got tn=%b c=%0d v=%b d=%h expected 0 12 1 12",
                     s0_tnext, cnt0, m0_valid, m0_data);
        end
        step();
        m0_auto = 1'b1;
        send0(4'h4, 1'b0, w);
        send0(4'h5, 1'b0, w);
        f0 = 1'b1;
        step();
        f0 = 1'b0;
        repeat (3) step();
        check_q0("backpressure", '{9'h112, 9'h034, 9'h050});
        checks++;
        if (cnt0 !== 16'd0) begin
            errors++;
            $display("FAIL backpressure_drain: got %0d expected 0", cnt0);
        end
    endtask

    task automatic test_wide_to_narrow();
        logic       e_tn[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       e_v[6]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] e_d[6]  = '{4'h0, 4'hA, 4'h5, 4'h3, 4'hC, 4'h0};
        logic       e_t[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        s3_valid = 1'b1; s3_data = 8'hA5; s3_first = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checks++;
            if ({s3_tnext, m3_valid, m3_data, m3_first} !== {e_tn[c], e_v[c], e_d[c], e_t[c]}) begin
                errors++;
                $display("FAIL w2n_cycle%0d: got tn=%b v=%b d=%h t=%b expected %b %b %h %b",
                         c, s3_tnext, m3_valid, m3_data, m3_first, e_tn[c], e_v[c], e_d[c], e_t[c]);
            end
            step();
            if (c == 0) begin s3_data = 8'h3C; s3_first = 1'b0; end
            if (c == 2) s3_valid = 1'b0;
        end
    endtask

    task automatic test_async_reset();
        int w;
        send0(4'h9, 1'b1, w);
        s0_valid = 1'b1; s0_data = 4'h7; s0_first = 1'b0;
        checks++;
        if (cnt0 !== 16'd4) begin
            errors++;
            $display("FAIL areset_pre: got %0d expected 4", cnt0);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({m0_valid, s0_tnext, cnt0, m0_data, m0_first} !== '0) begin
            errors++;
            $display("FAIL areset_now: got v=%b tn=%b c=%0d d=%h expected 0", m0_valid, s0_tnext, cnt0, m0_data);
        end
        s0_valid = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        step();
        q0.delete();
        send0(4'h7, 1'b0, w);
        send0(4'h8, 1'b0, w);
        repeat (3) step();
        check_q0("areset", '{9'h078});
    endtask

    initial begin
        test_reset();
        test_narrow_to_wide();
        test_odd_ratio_flush();
        test_packet_boundary();
        test_back_to_back();
        test_wide_to_narrow();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
